// File: rtl/io_model_pkg.sv
// Shared definitions for the I/O model library.
// Holds the deserializer FSM states and the legal word-width range.
package io_model_pkg;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SLIP_LOCK
    } ser_state_t;

endpackage

// File: rtl/i_deserializer.sv
// SDR serial-to-parallel input converter, MSB first.
// Bitslip moves the word boundary one bit later per accepted request.
module i_deserializer
    import io_model_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             D,
    input  logic             BITSLIP_ADJ,
    output logic [WIDTH-1:0] Q,
    output logic             DATA_VALID,
    output logic             SLIP_BUSY
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("i_deserializer: WIDTH %0d outside %0d..%0d",
                   WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    ser_state_t       state;
    ser_state_t       state_nx;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic [WIDTH-1:0] q_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             dv_nx;
    logic             busy_nx;
    logic             slip;
    logic             done;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and datapath: shift, count, slip, word completion
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        q_nx     = Q;
        dv_nx    = 1'b0;
        busy_nx  = SLIP_BUSY;
        slip     = 1'b0;
        done     = 1'b0;
        if (!EN) begin
            state_nx = IDLE;
            sr_nx    = '0;
            cnt_nx   = '0;
            busy_nx  = 1'b0;
        end else begin
            sr_nx = {sr[WIDTH-2:0], D};
            slip  = BITSLIP_ADJ && (state != SLIP_LOCK);
            done  = !slip && (cnt == LAST);
            if (slip) begin
                state_nx = SLIP_LOCK;
                busy_nx  = 1'b1;
            end else if (done) begin
                state_nx = RUN;
                q_nx     = sr_nx;
                dv_nx    = 1'b1;
                cnt_nx   = '0;
                busy_nx  = 1'b0;
            end else begin
                cnt_nx = cnt + 1'b1;
                if (state == IDLE) begin
                    state_nx = RUN;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr         <= '0;
            cnt        <= '0;
            Q          <= '0;
            DATA_VALID <= 1'b0;
            SLIP_BUSY  <= 1'b0;
        end else begin
            sr         <= sr_nx;
            cnt        <= cnt_nx;
            Q          <= q_nx;
            DATA_VALID <= dv_nx;
            SLIP_BUSY  <= busy_nx;
        end
    end

endmodule
